// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU result path:
//   - opcode class constants (alu_opcode[3:2] selects the class)
//   - bit positions of the status flags inside a 4-bit flag vector
//   - alu_result_t : one queued entry, {flags, y}
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_WIDTH = 8;

   // Opcode classes. An opcode with [3:2] == OPC_ARITH is an adder/subtractor
   // result; bit 2 marks the logic unit and bit 3 marks the shifter.
   localparam logic [1:0] OPC_ARITH     = 2'b00;
   localparam int         OPC_LOGIC_BIT = 2;
   localparam int         OPC_SHIFT_BIT = 3;

   // Flag vector layout {S,C,N,Z}.
   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_S = 3;

   typedef struct packed {
      logic [3:0]           flags;
      logic [ALU_WIDTH-1:0] y;
   } alu_result_t;

endpackage

// File: rtl/alu_result_queue_flag_gen.sv
// -----------------------------------------------------------------------------
// alu_flag_gen
// Combinational status flags for one ALU result.
// Ports:
//   alu_y      in   WIDTH  ALU result
//   alu_carry  in   1      ALU carry_out
//   alu_opcode in   4      opcode that produced alu_y
//   flags      out  4      {S,C,N,Z}
// -----------------------------------------------------------------------------
module alu_flag_gen
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] alu_y,
   input  logic             alu_carry,
   input  logic [3:0]       alu_opcode,
   output logic [3:0]       flags
);

   always_comb begin
      flags         = 4'b0000;
      flags[FLAG_Z] = (alu_y == '0);
      flags[FLAG_N] = alu_y[WIDTH-1];
      // Carry only carries meaning for the arithmetic class; logic and shift
      // units leave carry_out undefined, so it is masked.
      flags[FLAG_C] = alu_carry & (alu_opcode[3:2] == OPC_ARITH);
      flags[FLAG_S] = alu_opcode[OPC_SHIFT_BIT];
   end

endmodule

// File: rtl/alu_result_queue.sv
// -----------------------------------------------------------------------------
// alu_result_queue
// Captures ALU results with their derived flags and buffers them in a small
// first-word-fall-through FIFO toward a consumer that may stall.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   flush                  synchronous clear of all queued entries
//   in_valid / in_ready    producer handshake; alu_y/alu_carry/alu_opcode
//   out_valid / out_ready  consumer handshake; out_y/out_flags ({S,C,N,Z})
//   level                  number of entries currently stored
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Ready never depends on the same side's valid; valid data must stay
// stable until taken. in_ready = (level != DEPTH): a full queue refuses
// pushes even when a pop happens in the same cycle. out_valid = (level != 0),
// and out_y/out_flags read 0 while out_valid is 0.
// -----------------------------------------------------------------------------
module alu_result_queue
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           alu_y,
   input  logic                       alu_carry,
   input  logic [3:0]                 alu_opcode,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_y,
   output logic [3:0]                 out_flags,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

   alu_result_t       mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [LW-1:0]     count;
   logic [3:0]        new_flags;
   logic              push;
   logic              pop;

   alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
      .alu_y      (alu_y),
      .alu_carry  (alu_carry),
      .alu_opcode (alu_opcode),
      .flags      (new_flags)
   );

   assign in_ready  = (count != FULL_LEVEL);
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign level     = count;

   // Gating with out_valid keeps stale or never-written storage off the outputs.
   assign out_y     = out_valid ? mem[rd_ptr].y     : '0;
   assign out_flags = out_valid ? mem[rd_ptr].flags : 4'b0000;

   // Pointers wrap naturally because DEPTH is a power of two; the separate
   // count distinguishes full from empty when the pointers are equal.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible behind out_valid.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr].y     <= alu_y;
         mem[wr_ptr].flags <= new_flags;
      end
   end

endmodule

// File: tb/tb_alu_result_queue.sv
// -----------------------------------------------------------------------------
// tb_alu_result_queue
// Directed bench for alu_result_queue (WIDTH=8, DEPTH=4).
// -----------------------------------------------------------------------------
module tb_alu_result_queue;
   import alu_pkg::*;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] alu_y = 8'h00;
   logic       alu_carry = 1'b0;
   logic [3:0] alu_opcode = 4'h0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_y;
   logic [3:0] out_flags;
   logic [2:0] level;

   always #5 clk = ~clk;

   alu_result_queue #(.WIDTH(8), .DEPTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .alu_y      (alu_y),
      .alu_carry  (alu_carry),
      .alu_opcode (alu_opcode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_y      (out_y),
      .out_flags  (out_flags),
      .level      (level)
   );

   // ---------------- scoreboard ----------------
   int          checks = 0;
   int          errors = 0;
   logic [11:0] exp_q[$];   // {flags, y} in expected pop order
   logic [11:0] head;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Advance one edge; inputs change and outputs are sampled 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [7:0] y, input logic [3:0] op,
                         input logic c);
      in_valid   = v;
      alu_y      = y;
      alu_opcode = op;
      alu_carry  = c;
   endtask

   task automatic pop_check(input string tag);
      head = exp_q.pop_front();
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_y"},     32'(out_y),     32'(head[7:0]));
      check({tag, "_flags"}, 32'(out_flags), 32'(head[11:8]));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
      check("rst_level",  32'(level),     32'd0);
      check("rst_valid",  32'(out_valid), 32'd0);
      check("rst_ready",  32'(in_ready),  32'd1);
      check("rst_y",      32'(out_y),     32'd0);
      check("rst_flags",  32'(out_flags), 32'd0);

      // Zero result from arithmetic op with carry: Z and C set.
      set_in(1'b1, 8'h00, 4'b0000, 1'b1);
      step();
      set_in(1'b0, 8'h00, 4'b0000, 1'b0);
      check("t2_level", 32'(level), 32'd1);
      exp_q.push_back({4'b0101, 8'h00});
      pop_check("t2");
      check("t2_empty_valid", 32'(out_valid), 32'd0);
      check("t2_empty_y",     32'(out_y),     32'd0);
      check("t2_empty_flags", 32'(out_flags), 32'd0);

      // Logic op: carry masked, N from bit 7.
      set_in(1'b1, 8'h80, 4'b0100, 1'b1);
      step();
      exp_q.push_back({4'b0010, 8'h80});
      // Shift op: S set, carry masked.
      set_in(1'b1, 8'h01, 4'b1000, 1'b1);
      step();
      set_in(1'b0, 8'h00, 4'b0000, 1'b0);
      exp_q.push_back({4'b1000, 8'h01});
      check("t3_level", 32'(level), 32'd2);
      pop_check("t3a");
      pop_check("t3b");

      // Push with out_ready asserted while empty: push only.
      set_in(1'b1, 8'h7f, 4'b0001, 1'b1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      set_in(1'b0, 8'h00, 4'b0000, 1'b0);
      exp_q.push_back({4'b0100, 8'h7f});
      check("empty_pushpop_level", 32'(level), 32'd1);
      pop_check("empty_pushpop");

      // Fill: five pushes, only four accepted.
      for (int i = 1; i <= 5; i++) begin
         set_in(1'b1, 8'(i), 4'b0001, 1'b0);
         step();
         if (i <= 4) exp_q.push_back({4'b0000, 8'(i)});
      end
      check("full_level", 32'(level),    32'd4);
      check("full_ready", 32'(in_ready), 32'd0);
      // Held 5th item with pop in the same cycle: pop only, no pass-through.
      out_ready = 1'b1;
      head = exp_q.pop_front();
      check("full_head_y", 32'(out_y), 32'(head[7:0]));
      step();
      out_ready = 1'b0;
      set_in(1'b0, 8'h00, 4'b0000, 1'b0);
      check("full_pop_level", 32'(level), 32'd3);
      for (int i = 0; i < 3; i++) pop_check("full_drain");
      check("full_drain_level", 32'(level), 32'd0);

      // level=2, sustained push+pop across pointer wrap.
      set_in(1'b1, 8'h11, 4'b0000, 1'b0);
      step();
      set_in(1'b1, 8'h92, 4'b0000, 1'b1);
      step();
      exp_q.push_back({4'b0000, 8'h11});
      exp_q.push_back({4'b0110, 8'h92});
      check("t5_level", 32'(level), 32'd2);
      for (int i = 0; i < 5; i++) begin
         set_in(1'b1, 8'(8'h40 + i), 4'b0000, 1'b0);
         out_ready = 1'b1;
         head = exp_q.pop_front();
         check("t5_head_y",     32'(out_y),     32'(head[7:0]));
         check("t5_head_flags", 32'(out_flags), 32'(head[11:8]));
         step();
         exp_q.push_back({4'b0000, 8'(8'h40 + i)});
         check("t5_level_hold", 32'(level), 32'd2);
      end
      out_ready = 1'b0;
      set_in(1'b0, 8'h00, 4'b0000, 1'b0);
      pop_check("t5_drain");
      pop_check("t5_drain");

      // level=3, flush with in_valid=1: everything dropped.
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 8'(8'h20 + i), 4'b0000, 1'b0);
         step();
      end
      check("t6_level", 32'(level), 32'd3);
      flush = 1'b1;
      set_in(1'b1, 8'h55, 4'b0000, 1'b0);
      out_ready = 1'b1;
      step();
      flush = 1'b0;
      out_ready = 1'b0;
      set_in(1'b0, 8'h00, 4'b0000, 1'b0);
      check("t6_flush_level", 32'(level),     32'd0);
      check("t6_flush_valid", 32'(out_valid), 32'd0);
      check("t6_flush_y",     32'(out_y),     32'd0);
      step();
      check("t6_dropped_level", 32'(level), 32'd0);

      // Async reset mid-stream at level=3.
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 8'(8'hc0 + i), 4'b0000, 1'b0);
         step();
      end
      set_in(1'b0, 8'h00, 4'b0000, 1'b0);
      check("t1_level_before", 32'(level), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("t1_level", 32'(level),     32'd0);
      check("t1_valid", 32'(out_valid), 32'd0);
      check("t1_y",     32'(out_y),     32'd0);
      check("t1_flags", 32'(out_flags), 32'd0);
      check("t1_ready", 32'(in_ready),  32'd1);
      step();
      rst_n = 1'b1;
      step();
      check("t1_after_level", 32'(level), 32'd0);

      // ---------------- report ----------------
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
